// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle between the CPU pipeline and the multiply/divide unit.
// The master is the pipeline side. It drives operands, the launch strobe and
// the MTHI/MTLO writes. The slave is muldiv_unit, which returns busy, done and HI/LO.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// op: 00=MULTU, 01=MULT, 10=DIVU, 11=DIV. Signed operations run on operand
// magnitudes, and the result signs are fixed up when HI/LO are written.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one RUN
// cycle through a combinational product. Divide timing does not change.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | one multiply/divide step per cycle; HI/LO held until the last step
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] op_b;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
`else
    logic [WIDTH:0]     mul_sum;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand conditioning at launch: magnitudes for signed ops, raw for unsigned
    always_comb begin
        sign_a = bus.op[0] & bus.opa[WIDTH-1];
        sign_b = bus.op[0] & bus.opb[WIDTH-1];
        mag_a  = sign_a ? -bus.opa : bus.opa;
        mag_b  = sign_b ? -bus.opb : bus.opb;
    end

    // One datapath step: shift-add multiply or restoring shift-subtract divide
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{WIDTH{1'b0}}, acc_lo} * {{WIDTH{1'b0}}, op_b};
`else
        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, op_b}) : {1'b0, acc_hi};
`endif
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_b};
        // The borrow bit is clear exactly when the shifted remainder is >= divisor
        div_ge    = ~div_diff[WIDTH];
        if (is_div) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            step_hi = fast_prod[2*WIDTH-1:WIDTH];
            step_lo = fast_prod[WIDTH-1:0];
`else
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
        end
    end

    // Sign fix-up of the final magnitude result; divide-by-zero forces quotient to all ones
    always_comb begin
        if (!is_div) begin
            {res_hi, res_lo} = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        end else begin
            res_lo = div_zero ? '1 : (neg_q ? -step_lo : step_lo);
            // Remainder follows the dividend sign. For a zero divisor this restores opa exactly.
            res_hi = neg_r ? -step_hi : step_hi;
        end
    end

    // Control FSM, datapath registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_b     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // A launch takes priority, so any MTHI/MTLO in the same cycle is dropped
                        state    <= RUN;
                        busy_q   <= 1'b1;
                        is_div   <= bus.op[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= bus.op[1] & (bus.opb == '0);
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        op_b     <= mag_b;
`ifdef MULDIV_FAST_MUL_EN
                        cnt      <= bus.op[1] ? CNT_W'(WIDTH) : CNT_W'(1);
`else
                        cnt      <= CNT_W'(WIDTH);
`endif
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wdata;
                        if (bus.wr_lo) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Expected HI/LO pairs go into a scoreboard
// queue at launch and are popped when done pulses.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_vec        = 0;
    int   n_miscompare = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscompare++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_busy(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return op[1] ? W : 1;
`else
        return W;
`endif
    endfunction

    // Launch one operation from the current negedge, then wait for done (bounded).
    // On return the bench sits at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input bit wr_lo_start, input bit wr_lo_busy);
        exp_t         e;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int           busy_cnt = 0;
        int           cyc      = 0;
        bit           held     = 1'b1;
        bit           seen     = 1'b0;
        e.tag = tag;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        sb.push_back(e);
        prev_hi   = bus.hi;
        prev_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        if (wr_lo_start) begin
            bus.wr_lo = 1'b1;
            bus.wdata = 32'hA5A5_A5A5;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        bus.opa   = ~a;
        bus.opb   = ~b;
        if (wr_lo_busy) begin
            bus.wr_lo = 1'b1;
            bus.wdata = 32'hDEAD_BEEF;
        end
        while (!seen && cyc < 200) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.hi !== prev_hi || bus.lo !== prev_lo) held = 1'b0;
                @(negedge clk);
                bus.wr_lo = 1'b0;
                cyc++;
            end
        end
        check({tag, ".done_seen"}, seen, 1);
        check({tag, ".busy_at_done"}, bus.busy, 0);
        check({tag, ".busy_cycles"}, busy_cnt, exp_busy(op));
        check({tag, ".hilo_held"}, held, 1);
        check({tag, ".sb_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".hi"}, bus.hi, e.hi);
            check({e.tag, ".lo"}, bus.lo, e.lo);
        end
    endtask

    initial begin
        logic [W-1:0] lo_before;
        logic [W-1:0] hi_before;
        bit           stray_done;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = '0;
        bus.opb   = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;

        @(negedge clk);
        @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.hi", bus.hi, 0);
        check("reset.lo", bus.lo, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        @(negedge clk);
        check("multu_max.done_pulse_width", bus.done, 0);

        run_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
        run_op("divu_b2b", 2'b10, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 0, 0);
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0);
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 0, 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
        run_op("div_neg_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0);
        run_op("mult_m1xm1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
        run_op("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
        @(negedge clk);

        lo_before = bus.lo;
        bus.wr_hi = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        check("mthi.hi", bus.hi, 32'h1234_5678);
        check("mthi.lo_kept", bus.lo, lo_before);
        check("mthi.no_done", bus.done, 0);
        hi_before = bus.hi;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        check("mtlo.lo", bus.lo, 32'h9ABC_DEF0);
        check("mtlo.hi_kept", bus.hi, hi_before);
        check("mtlo.no_done", bus.done, 0);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check("mthilo.hi", bus.hi, 32'hCAFE_F00D);
        check("mthilo.lo", bus.lo, 32'hCAFE_F00D);
        check("mthilo.no_done", bus.done, 0);

        run_op("start_with_mtlo", 2'b00, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1, 0);
        run_op("mtlo_while_busy", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 0, 1);
        @(negedge clk);

        // Abort an operation with reset ten cycles after launch
        bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        bus.op    = 2'b10;
`else
        bus.op    = 2'b00;
`endif
        bus.opa   = 32'hFFFF_FFFF;
        bus.opb   = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("abort.busy_before", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", bus.busy, 0);
        check("abort.hi", bus.hi, 0);
        check("abort.lo", bus.lo, 0);
        stray_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.done || bus.busy) stray_done = 1'b1;
            @(negedge clk);
        end
        check("abort.no_done", stray_done, 0);

        run_op("multu_after_abort", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 0);
        @(negedge clk);
        check("final.sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end
endmodule
